// File: rtl/reception8_pkg.sv
// Shared definitions for the 8-channel select-line link (receiver FSM states,
// channel count and select width).
package reception8_pkg;
    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;
endpackage

// File: rtl/reception8_dwell_timer.sv
// Counts the cycles a channel select has been held; last marks the sample cycle.
module dwell_timer #(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign last = (cnt_q == CW'(DWELL - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/reception8.sv
// Receiver for the transmission8 link: walks the channel select 0..7, samples
// the returned data line per channel and hands a full byte out via valid/ready.
module reception8
    import reception8_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iStart,
    input  logic       iSerial,
    input  logic       iReady,
    output logic       oA,
    output logic       oB,
    output logic       oC,
    output logic [7:0] oData,
    output logic       oValid,
    output logic       oBusy,
    output logic       oOverrun
);
    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NCH-1:0]     shadow_q, shadow_d;
    logic [NCH-1:0]     data_q, data_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               ovr_q, ovr_d;
    logic               tmr_clr, tmr_en, tmr_last;

    // Timer is held clear outside SHIFT so every frame starts on a fresh dwell.
    assign tmr_clr = (state_q != SHIFT);
    assign tmr_en  = (state_q == SHIFT);

    dwell_timer #(.DWELL(DWELL)) u_dwell (
        .clk   (iClk),
        .rst_n (iRst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .last  (tmr_last)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ovr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                sel_d = '0;
                if (iStart) state_d = SHIFT;
            end
            SHIFT: begin
                if (iStart) ovr_d = 1'b1;
                if (tmr_last) begin
                    shadow_d[sel_q] = iSerial;
                    if (sel_q == SEL_W'(NCH - 1)) begin
                        // Last channel goes straight into the output word.
                        data_d  = {iSerial, shadow_q[NCH-2:0]};
                        valid_d = 1'b1;
                        sel_d   = '0;
                        state_d = HOLD;
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                sel_d = '0;
                if (iReady) begin
                    valid_d = 1'b0;
                    state_d = iStart ? SHIFT : IDLE;
                end else if (iStart) begin
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            ovr_q    <= ovr_d;
        end
    end

    assign oA       = sel_q[2];
    assign oB       = sel_q[1];
    assign oC       = sel_q[0];
    assign oData    = data_q;
    assign oValid   = valid_q;
    assign oBusy    = busy_q;
    assign oOverrun = ovr_q;
endmodule

// File: tb/tb_reception8.sv
// Bench: two receivers (DWELL=2 and DWELL=1), each fed by a transmission8
// model that returns src[sel] on the data line.
module tb_reception8;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start [2];
    logic       ready [2];
    logic [7:0] src   [2];
    logic [7:0] prev  [2];
    logic       ser   [2];
    logic       a [2], b [2], c [2];
    logic [2:0] sel   [2];
    logic [7:0] data  [2];
    logic       valid [2], busy [2], ovr [2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reception8 #(.DWELL(2)) u_d2 (
        .iClk(clk), .iRst_n(rst_n), .iStart(start[0]), .iSerial(ser[0]), .iReady(ready[0]),
        .oA(a[0]), .oB(b[0]), .oC(c[0]), .oData(data[0]), .oValid(valid[0]),
        .oBusy(busy[0]), .oOverrun(ovr[0])
    );

    reception8 #(.DWELL(1)) u_d1 (
        .iClk(clk), .iRst_n(rst_n), .iStart(start[1]), .iSerial(ser[1]), .iReady(ready[1]),
        .oA(a[1]), .oB(b[1]), .oC(c[1]), .oData(data[1]), .oValid(valid[1]),
        .oBusy(busy[1]), .oOverrun(ovr[1])
    );

    for (genvar i = 0; i < 2; i++) begin : g_link
        assign sel[i] = {a[i], b[i], c[i]};
        assign ser[i] = src[i][sel[i]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int d, input logic [7:0] s);
        src[d]   = s;
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
    endtask

    // Called just after the capture edge; the model expects select j/DWELL after
    // j further edges and the completed byte after 8*DWELL edges.
    task automatic shift_phase(input int d, input int ovr_at);
        int dw;
        dw = (d == 0) ? 2 : 1;
        for (int j = 0; j < 8 * dw; j++) begin
            chk("sel_step", 32'(sel[d]), 32'(j / dw));
            chk("valid_shift", 32'(valid[d]), 0);
            chk("busy_shift", 32'(busy[d]), 1);
            chk("data_stable", 32'(data[d]), 32'(prev[d]));
            chk("ovr_shift", 32'(ovr[d]), 32'((ovr_at >= 0) && (j == ovr_at + 1)));
            start[d] = (j == ovr_at);
            ready[d] = 1'($urandom);
            tick();
        end
        start[d] = 1'b0;
        chk("valid_done", 32'(valid[d]), 1);
        chk("data_done", 32'(data[d]), 32'(src[d]));
        chk("sel_hold", 32'(sel[d]), 0);
        prev[d] = src[d];
    endtask

    task automatic hold_phase(input int d, input int wait_n, input int ovr_at,
                              input bit b2b, input logic [7:0] nxt);
        logic [7:0] frame;
        frame = src[d];
        for (int i = 0; i < wait_n; i++) begin
            chk("valid_hold", 32'(valid[d]), 1);
            chk("busy_hold", 32'(busy[d]), 1);
            chk("data_hold", 32'(data[d]), 32'(frame));
            chk("ovr_hold", 32'(ovr[d]), 32'((ovr_at >= 0) && (i == ovr_at + 1)));
            ready[d] = 1'b0;
            start[d] = (i == ovr_at);
            tick();
        end
        ready[d] = 1'b1;
        start[d] = b2b;
        if (b2b) src[d] = nxt;
        tick();
        ready[d] = 1'b0;
        start[d] = 1'b0;
        chk("valid_accept", 32'(valid[d]), 0);
        chk("busy_accept", 32'(busy[d]), 32'(b2b));
        chk("sel_accept", 32'(sel[d]), 0);
        chk("data_accept", 32'(data[d]), 32'(frame));
        if (!b2b) begin
            tick();
            chk("busy_idle", 32'(busy[d]), 0);
            chk("valid_idle", 32'(valid[d]), 0);
        end
    endtask

    initial begin
        int d, dw, w, oa, ho;
        bit bb;
        logic [7:0] s, nxt;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; ready[i] = 1'b0; src[i] = '0; prev[i] = '0;
        end
        #12;
        for (int i = 0; i < 2; i++) begin
            chk("rst_sel", 32'(sel[i]), 0);
            chk("rst_data", 32'(data[i]), 0);
            chk("rst_valid", 32'(valid[i]), 0);
            chk("rst_busy", 32'(busy[i]), 0);
            chk("rst_ovr", 32'(ovr[i]), 0);
        end
        rst_n = 1'b1;
        tick();

        // Basic frame with ready asserted, then a held frame with an ignored start.
        ready[0] = 1'b1;
        start_frame(0, 8'h0F);
        shift_phase(0, -1);
        hold_phase(0, 0, -1, 1'b0, 8'h00);
        start_frame(0, 8'hAA);
        shift_phase(0, -1);
        hold_phase(0, 5, 2, 1'b0, 8'h00);

        // Start during SHIFT is dropped and flagged for one cycle.
        start_frame(0, 8'h3C);
        shift_phase(0, 5);
        hold_phase(0, 1, -1, 1'b0, 8'h00);

        // Back-to-back: accept and restart on the same edge.
        start_frame(0, 8'h0F);
        shift_phase(0, -1);
        hold_phase(0, 2, -1, 1'b1, 8'hAA);
        shift_phase(0, -1);
        hold_phase(0, 0, -1, 1'b0, 8'h00);

        // Asynchronous reset mid-frame at channel 4.
        start_frame(0, 8'hC3);
        for (int j = 0; j < 8; j++) tick();
        chk("sel_pre_rst", 32'(sel[0]), 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sel", 32'(sel[0]), 0);
        chk("arst_busy", 32'(busy[0]), 0);
        chk("arst_valid", 32'(valid[0]), 0);
        chk("arst_data", 32'(data[0]), 0);
        #3;
        rst_n = 1'b1;
        prev[0] = '0;
        tick();
        start_frame(0, 8'h96);
        shift_phase(0, -1);
        hold_phase(0, 0, -1, 1'b0, 8'h00);

        // DWELL=1 instance.
        start_frame(1, 8'h5A);
        shift_phase(1, -1);
        hold_phase(1, 0, -1, 1'b0, 8'h00);

        // Randomized frames on both instances.
        for (int n = 0; n < 24; n++) begin
            d  = n % 2;
            dw = (d == 0) ? 2 : 1;
            s  = 8'($urandom);
            start_frame(d, s);
            for (int k = 0; k < 3; k++) begin
                oa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8 * dw - 2)) : -1;
                shift_phase(d, oa);
                w   = int'($urandom_range(0, 4));
                ho  = (w > 1) ? int'($urandom_range(0, w - 2)) : -1;
                bb  = (k < 2) && ($urandom_range(0, 1) == 1);
                nxt = 8'($urandom);
                hold_phase(d, w, ho, bb, nxt);
                if (!bb) break;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
